dmem_responder: RTL

Data-side memory responder for the 5-stage pipelined MIPS CPU: the slave end of the MEM-stage interface (mem_ren / mem_wen / mem_addr / mem_dout / mem_din). It holds a word-addressed data RAM and services one request at a time with a fixed multi-cycle latency. It drives a stall flag that the pipeline controller uses to hold the stage enables until the access completes.

---
 rtl/dmem_responder.sv | 115 +++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-side memory responder: word-addressed RAM serving one MEM-stage request at a time
// with a fixed latency. Define MEM_STATS_EN to add the stat_reads/stat_writes counters.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        mem_stall,
`ifdef MEM_STATS_EN
    output logic [15:0] stat_reads,
    output logic [15:0] stat_writes,
`endif
    output logic        mem_fault
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [3:0] LATENCY = 4'(MEM_LATENCY);

    logic [31:0] ram [0:(2**ADDR_WIDTH)-1];

    logic [1:0]            state_reg;
    logic [3:0]            cnt_reg;
    logic [ADDR_WIDTH-1:0] idx_reg;
    logic [31:0]           data_reg;
    logic                  write_reg;
    logic                  illegal_reg;

    logic req;
    logic req_illegal;
    logic access_now;
    logic unused_addr_bits;

    assign req         = mem_ren | mem_wen;
    assign req_illegal = (|mem_addr[1:0]) | (mem_ren & mem_wen);
    assign access_now  = (state_reg == ST_WAIT) && (cnt_reg == 4'd1);
    assign mem_stall   = ((state_reg == ST_IDLE) && req) || (state_reg == ST_WAIT);

    // Address bits above the RAM index alias onto the same words.
    assign unused_addr_bits = &{1'b0, mem_addr[31:ADDR_WIDTH+2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 4'd0;
            idx_reg     <= '0;
            data_reg    <= 32'd0;
            write_reg   <= 1'b0;
            illegal_reg <= 1'b0;
            mem_din     <= 32'd0;
            mem_fault   <= 1'b0;
        end else begin
            mem_fault <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        idx_reg     <= mem_addr[ADDR_WIDTH+1:2];
                        data_reg    <= mem_dout;
                        write_reg   <= mem_wen;
                        illegal_reg <= req_illegal;
                        cnt_reg     <= LATENCY;
                        state_reg   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (access_now) begin
                        state_reg <= ST_DONE;
                        mem_fault <= illegal_reg;
                        if (!write_reg && !illegal_reg) begin
                            mem_din <= ram[idx_reg];
                        end
                    end
                end
                default: begin
                    // The request still present here is the one just served.
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (access_now && write_reg && !illegal_reg) begin
            ram[idx_reg] <= data_reg;
        end
    end

`ifdef MEM_STATS_EN
    logic done_legal;
    assign done_legal = (state_reg == ST_DONE) && !illegal_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_reads  <= 16'd0;
            stat_writes <= 16'd0;
        end else if (done_legal) begin
            if (write_reg && (stat_writes != 16'hFFFF)) begin
                stat_writes <= stat_writes + 16'd1;
            end
            if (!write_reg && (stat_reads != 16'hFFFF)) begin
                stat_reads <= stat_reads + 16'd1;
            end
        end
    end
`endif

endmodule
